// File: rtl/gpu_display_ctrl.sv
// gpu_display_ctrl: display back-end for the reduced GPU.
// Turns the raw timing counters into pixel coordinates for the renderers,
// picks the highest-priority opaque layer (or the background) and registers
// it together with the syncs.  Also hosts a small bus-mapped block with
// interrupt status/enable, layer enables, a raster line compare and a
// frame counter.
module gpu_display_ctrl #(
  parameter int COLOR_BITS = 2,
  parameter int NUM_LAYERS = 2,
  parameter int H_OFFSET   = 32,
  parameter int Y_SHIFT    = 1,
  parameter int ACTIVE_W   = 256,
  parameter int ACTIVE_H   = 240
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [9:0]                     hcounter,
  input  logic [9:0]                     vcounter,
  input  logic                           visible,
  input  logic                           writable,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  output logic [8:0]                     current_x,
  output logic [8:0]                     current_y,
  input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]          layer_valid,
  input  logic [3*COLOR_BITS-1:0]        bg_rgb,
  output logic [COLOR_BITS-1:0]          r,
  output logic [COLOR_BITS-1:0]          g,
  output logic [COLOR_BITS-1:0]          b,
  output logic                           hsync,
  output logic                           vsync,
  input  logic [7:0]                     data_in,
  inout  wire  [7:0]                     data_out,
  input  logic [2:0]                     reg_addr,
  input  logic                           write_enable,
  input  logic                           sel_regs,
  output logic                           irq
);

  localparam int RGB_W = 3 * COLOR_BITS;
  // Implemented LAYER_EN bits: one per layer plus the background enable at bit 7.
  localparam logic [7:0] LAYER_MASK = 8'h80 | 8'((1 << NUM_LAYERS) - 1);

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd1;
  localparam logic [2:0] ADDR_LAYER_EN = 3'd2;
  localparam logic [2:0] ADDR_LINE_CMP = 3'd3;
  localparam logic [2:0] ADDR_FRAME    = 3'd4;

  // Register state
  logic [2:0]       status_reg;     // {LINE, VBE, VBS}
  logic [2:0]       irq_en_reg;     // gates for {LINE, VBE, VBS}
  logic [7:0]       layer_en_reg;
  logic [7:0]       line_cmp_reg;
  logic [7:0]       frame_reg;
  logic             writable_prev_reg;
  logic             irq_reg;
  logic [RGB_W-1:0] rgb_reg;
  logic             hsync_reg;
  logic             vsync_reg;

  logic [2:0]       status_next;
  logic [RGB_W-1:0] rgb_next;
  logic [7:0]       rd_data;

  // ------------------------------------------------------------------
  // Coordinates and drawing window
  // ------------------------------------------------------------------
  logic [9:0] vshift;
  logic       drawing;

  assign vshift    = vcounter >> Y_SHIFT;
  assign current_x = hcounter[8:0] - 9'(H_OFFSET);
  assign current_y = vshift[8:0];
  assign drawing   = visible && (32'(current_x) < ACTIVE_W) && (32'(current_y) < ACTIVE_H);

  // ------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------
  logic bus_wr;
  logic wr_status;
  logic wr_layer_en;

  assign bus_wr      = sel_regs && write_enable;
  assign wr_status   = bus_wr && (reg_addr == ADDR_STATUS);
  assign wr_layer_en = bus_wr && (reg_addr == ADDR_LAYER_EN);

  // A LAYER_EN write already applies to the pixel captured on the write edge,
  // so the compositor looks through to the incoming bus value.
  logic [7:0] layer_en_eff;
  assign layer_en_eff = wr_layer_en ? (data_in & LAYER_MASK) : layer_en_reg;

  // ------------------------------------------------------------------
  // Compositor
  // ------------------------------------------------------------------
  logic [RGB_W-1:0]      layer_pix [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] layer_hit;

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      assign layer_pix[gi] = layer_rgb[gi*RGB_W +: RGB_W];
      assign layer_hit[gi] = layer_valid[gi] && layer_en_eff[gi];
    end
  endgenerate

  // Priority select: walking from the lowest priority upward lets layer 0 win.
  always_comb begin
    rgb_next = '0;
    if (drawing) begin
      if (layer_en_eff[7]) begin
        rgb_next = bg_rgb;
      end
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
        if (layer_hit[k]) begin
          rgb_next = layer_pix[k];
        end
      end
    end
  end

  // Pixel and sync output register (one stage, syncs stay aligned with RGB).
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_reg   <= '0;
      hsync_reg <= 1'b0;
      vsync_reg <= 1'b0;
    end else begin
      rgb_reg   <= rgb_next;
      hsync_reg <= hsync_in;
      vsync_reg <= vsync_in;
    end
  end

  assign r     = rgb_reg[3*COLOR_BITS-1 -: COLOR_BITS];
  assign g     = rgb_reg[2*COLOR_BITS-1 -: COLOR_BITS];
  assign b     = rgb_reg[COLOR_BITS-1   -: COLOR_BITS];
  assign hsync = hsync_reg;
  assign vsync = vsync_reg;

  // ------------------------------------------------------------------
  // Event sources
  // ------------------------------------------------------------------
  logic vbs_evt;
  logic vbe_evt;
  logic line_evt;
  logic line_low_ok;

  assign vbs_evt = writable && !writable_prev_reg;
  assign vbe_evt = !writable && writable_prev_reg;

  // With line doubling the compare must only hit on the first physical line
  // of each logical line.
  generate
    if (Y_SHIFT == 0) begin : g_no_shift
      assign line_low_ok = 1'b1;
    end else begin : g_shift
      assign line_low_ok = (vcounter[Y_SHIFT-1:0] == '0);
    end
  endgenerate

  assign line_evt = (vshift == {2'b00, line_cmp_reg}) && line_low_ok && (hcounter == 10'd0);

  // STATUS next state: write-1-to-clear, with a simultaneous set winning.
  always_comb begin
    status_next = status_reg;
    if (wr_status) begin
      status_next = status_reg & ~data_in[3:1];
    end
    status_next = status_next | {line_evt, vbe_evt, vbs_evt};
  end

  // Control/status registers, edge detector, frame counter and irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg        <= '0;
      irq_en_reg        <= '0;
      layer_en_reg      <= LAYER_MASK;
      line_cmp_reg      <= 8'hFF;
      frame_reg         <= '0;
      writable_prev_reg <= writable;
      irq_reg           <= 1'b0;
    end else begin
      status_reg        <= status_next;
      writable_prev_reg <= writable;
      irq_reg           <= |(status_reg & irq_en_reg);
      if (vbs_evt) begin
        frame_reg <= frame_reg + 8'd1;
      end
      if (bus_wr) begin
        case (reg_addr)
          ADDR_IRQ_EN:   irq_en_reg   <= data_in[3:1];
          ADDR_LAYER_EN: layer_en_reg <= data_in & LAYER_MASK;
          ADDR_LINE_CMP: line_cmp_reg <= data_in;
          default: ;
        endcase
      end
    end
  end

  assign irq = irq_reg;

  // ------------------------------------------------------------------
  // Read-back mux, driven onto the bus only for a selected read
  // ------------------------------------------------------------------
  always_comb begin
    rd_data = 8'h00;
    case (reg_addr)
      ADDR_STATUS:   rd_data = {4'b0000, status_reg, writable};
      ADDR_IRQ_EN:   rd_data = {4'b0000, irq_en_reg, 1'b0};
      ADDR_LAYER_EN: rd_data = layer_en_reg;
      ADDR_LINE_CMP: rd_data = line_cmp_reg;
      ADDR_FRAME:    rd_data = frame_reg;
      default:       rd_data = 8'h00;
    endcase
  end

  assign data_out = (sel_regs && !write_enable) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_gpu_display_ctrl.sv
// Directed testbench for gpu_display_ctrl (default parameters).
module tb_gpu_display_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hcounter = '0;
  logic [9:0] vcounter = '0;
  logic       visible = 1'b0;
  logic       writable = 1'b1;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [8:0] current_x;
  logic [8:0] current_y;
  logic [11:0] layer_rgb = {6'h15, 6'h3F};
  logic [1:0] layer_valid = '0;
  logic [5:0] bg_rgb = 6'h2A;
  logic [1:0] r, g, b;
  logic       hsync, vsync;
  logic [7:0] data_in = '0;
  wire  [7:0] data_out;
  logic [2:0] reg_addr = '0;
  logic       write_enable = 1'b0;
  logic       sel_regs = 1'b0;
  logic       irq;

  int total = 0;
  int bad = 0;

  gpu_display_ctrl dut (
    .clk(clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
    .visible(visible), .writable(writable), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .current_x(current_x), .current_y(current_y),
    .layer_rgb(layer_rgb), .layer_valid(layer_valid), .bg_rgb(bg_rgb),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
    .data_in(data_in), .data_out(data_out), .reg_addr(reg_addr),
    .write_enable(write_enable), .sel_regs(sel_regs), .irq(irq)
  );

  // Weak pull so an undriven bus reads back as all ones.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
      pullup (data_out[gi]);
    end
  endgenerate

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       vis;
    logic [1:0] lv;
    logic       hs;
    logic       vs;
    logic [5:0] exp_rgb;
  } pix_vec_t;

  pix_vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    sel_regs = 1'b1; write_enable = 1'b1; reg_addr = a; data_in = d;
    tick();
    sel_regs = 1'b0; write_enable = 1'b0;
    $display("wr addr=%0d data=%02h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    sel_regs = 1'b1; write_enable = 1'b0; reg_addr = a;
    #1;
    d = data_out;
    sel_regs = 1'b0;
    #1;
    $display("rd addr=%0d data=%02h", a, d);
  endtask

  logic [7:0] rd;
  logic [7:0] exp_frame;
  logic [5:0] prev_rgb;
  logic       prev_hs, prev_vs;
  int         line_hits;
  int         hit_v, hit_h;
  int         irq_pulses;
  logic       clr;

  initial begin
    // hc, vc, vis, lv, hs, vs, expected rgb
    vecs[0]  = '{10'd42,  10'd10,  1'b1, 2'b11, 1'b1, 1'b0, 6'h3F}; // both opaque -> layer 0
    vecs[1]  = '{10'd42,  10'd10,  1'b1, 2'b10, 1'b0, 1'b1, 6'h15}; // only layer 1
    vecs[2]  = '{10'd42,  10'd10,  1'b1, 2'b00, 1'b1, 1'b1, 6'h2A}; // background
    vecs[3]  = '{10'd42,  10'd10,  1'b1, 2'b01, 1'b0, 1'b0, 6'h3F}; // only layer 0
    vecs[4]  = '{10'd20,  10'd10,  1'b1, 2'b11, 1'b1, 1'b0, 6'h00}; // x wraps to 500
    vecs[5]  = '{10'd42,  10'd480, 1'b1, 2'b11, 1'b0, 1'b1, 6'h00}; // y = 240
    vecs[6]  = '{10'd42,  10'd10,  1'b0, 2'b11, 1'b1, 1'b1, 6'h00}; // not visible
    vecs[7]  = '{10'd287, 10'd10,  1'b1, 2'b10, 1'b0, 1'b0, 6'h15}; // x = 255 last column
    vecs[8]  = '{10'd288, 10'd10,  1'b1, 2'b11, 1'b1, 1'b0, 6'h00}; // x = 256
    vecs[9]  = '{10'd42,  10'd479, 1'b1, 2'b00, 1'b0, 1'b1, 6'h2A}; // y = 239 last line
    vecs[10] = '{10'd31,  10'd10,  1'b1, 2'b11, 1'b1, 1'b1, 6'h00}; // x = 511

    // ---- reset, with pixel inputs that would otherwise draw ----
    rst = 1'b1; writable = 1'b1;
    hcounter = 10'd42; vcounter = 10'd10; visible = 1'b1; layer_valid = 2'b11;
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) tick();
    chk("reset_rgb", {r, g, b}, 6'h00);
    chk("reset_hsync", hsync, 1'b0);
    chk("reset_vsync", vsync, 1'b0);
    rst = 1'b0;
    visible = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (10) tick();
    chk("reset_irq", irq, 1'b0);
    bus_read(3'd0, rd); chk("reset_status", rd, 8'h01);
    bus_read(3'd1, rd); chk("reset_irq_en", rd, 8'h00);
    bus_read(3'd2, rd); chk("reset_layer_en", rd, 8'h83);
    bus_read(3'd3, rd); chk("reset_line_cmp", rd, 8'hFF);
    bus_read(3'd4, rd); chk("reset_frame", rd, 8'h00);
    exp_frame = 8'd0;

    // ---- table-driven pixel path ----
    prev_rgb = 6'h00; prev_hs = 1'b0; prev_vs = 1'b0;
    for (int i = 0; i < 11; i++) begin
      hcounter = vecs[i].hc; vcounter = vecs[i].vc; visible = vecs[i].vis;
      layer_valid = vecs[i].lv; hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
      #1;
      chk($sformatf("vec%0d_rgb_hold", i), {r, g, b}, prev_rgb);
      chk($sformatf("vec%0d_sync_hold", i), {hsync, vsync}, {prev_hs, prev_vs});
      tick();
      chk($sformatf("vec%0d_rgb", i), {r, g, b}, vecs[i].exp_rgb);
      chk($sformatf("vec%0d_sync", i), {hsync, vsync}, {vecs[i].hs, vecs[i].vs});
      $display("vec %0d x=%0d y=%0d rgb=%02h hs=%0b vs=%0b", i, current_x, current_y, {r, g, b}, hsync, vsync);
      prev_rgb = vecs[i].exp_rgb; prev_hs = vecs[i].hs; prev_vs = vecs[i].vs;
    end

    // ---- LAYER_EN writes hit the pixel on the write edge ----
    hcounter = 10'd42; vcounter = 10'd10; visible = 1'b1; layer_valid = 2'b11;
    hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    chk("layer_both", {r, g, b}, 6'h3F);
    bus_write(3'd2, 8'h82);
    chk("layer_en_82", {r, g, b}, 6'h15);
    bus_write(3'd2, 8'h00);
    chk("layer_en_00", {r, g, b}, 6'h00);
    bus_write(3'd2, 8'h80);
    chk("layer_en_80", {r, g, b}, 6'h2A);
    bus_write(3'd2, 8'hFF);
    bus_read(3'd2, rd); chk("layer_en_mask", rd, 8'h83);
    chk("layer_en_ff", {r, g, b}, 6'h3F);
    visible = 1'b0;

    // ---- IRQ_EN and vblank edges ----
    bus_write(3'd1, 8'hFF);
    bus_read(3'd1, rd); chk("irq_en_mask", rd, 8'h0E);
    bus_write(3'd1, 8'h02);
    bus_read(3'd1, rd); chk("irq_en_02", rd, 8'h02);
    writable = 1'b0;
    tick();
    bus_read(3'd0, rd); chk("vbe_status", rd, 8'h04);
    tick();
    chk("vbe_no_irq", irq, 1'b0);
    bus_write(3'd0, 8'h04);
    bus_read(3'd0, rd); chk("vbe_cleared", rd, 8'h00);
    writable = 1'b1;
    tick();
    exp_frame++;
    bus_read(3'd0, rd); chk("vbs_status", rd, 8'h03);
    chk("vbs_irq_lag", irq, 1'b0);
    bus_read(3'd4, rd); chk("vbs_frame", rd, exp_frame);
    tick();
    chk("vbs_irq", irq, 1'b1);
    bus_write(3'd0, 8'h02);
    chk("clr_irq_still", irq, 1'b1);
    bus_read(3'd0, rd); chk("vbs_cleared", rd, 8'h01);
    tick();
    chk("clr_irq_fall", irq, 1'b0);

    // clear coinciding with a fresh rising edge: set wins
    writable = 1'b0;
    tick();
    writable = 1'b1;
    sel_regs = 1'b1; write_enable = 1'b1; reg_addr = 3'd0; data_in = 8'h02;
    tick();
    sel_regs = 1'b0; write_enable = 1'b0;
    exp_frame++;
    bus_read(3'd0, rd); chk("set_beats_clear", rd, 8'h07);
    bus_write(3'd0, 8'h0E);
    bus_read(3'd0, rd); chk("status_all_clr", rd, 8'h01);
    tick(); tick();
    chk("irq_idle", irq, 1'b0);

    // ---- raster line compare over a compressed frame ----
    bus_write(3'd3, 8'd100);
    bus_write(3'd1, 8'h08);
    bus_write(3'd0, 8'h0E);
    line_hits = 0; hit_v = -1; hit_h = -1; irq_pulses = 0; clr = 1'b0;
    for (int v = 0; v < 525; v++) begin
      for (int h = 0; h < 4; h++) begin
        hcounter = 10'(h); vcounter = 10'(v);
        sel_regs = 1'b1; write_enable = clr; reg_addr = 3'd0; data_in = 8'h08;
        tick();
        clr = 1'b0; write_enable = 1'b0;
        #1;
        if (irq) irq_pulses++;
        if (data_out[3]) begin
          line_hits++; hit_v = v; hit_h = h; clr = 1'b1;
          $display("line event v=%0d h=%0d", v, h);
        end
      end
    end
    sel_regs = 1'b0;
    chk("line_hits", line_hits, 1);
    chk("line_hit_v", hit_v, 200);
    chk("line_hit_h", hit_h, 0);
    chk("line_irq_cycles", irq_pulses, 1);
    hcounter = 10'd5; vcounter = 10'd10;

    // ---- frame counter wrap ----
    for (int i = 0; i < 256; i++) begin
      writable = 1'b0;
      tick();
      writable = 1'b1;
      tick();
      exp_frame++;
      sel_regs = 1'b1; write_enable = 1'b0; reg_addr = 3'd4;
      #1;
      chk($sformatf("frame_%0d", i), data_out, exp_frame);
      sel_regs = 1'b0;
      if (exp_frame == 8'd0) $display("frame wrapped at edge %0d", i);
    end
    bus_write(3'd4, 8'h55);
    bus_read(3'd4, rd); chk("frame_ro", rd, exp_frame);
    for (int a = 5; a < 8; a++) begin
      bus_write(3'(a), 8'hFF);
      bus_read(3'(a), rd); chk($sformatf("addr%0d_zero", a), rd, 8'h00);
    end

    // ---- tri-state behaviour ----
    sel_regs = 1'b0; write_enable = 1'b0; reg_addr = 3'd2;
    #1; chk("z_unselected", data_out, 8'hFF);
    sel_regs = 1'b1; write_enable = 1'b1; reg_addr = 3'd5;
    #1; chk("z_on_write", data_out, 8'hFF);
    sel_regs = 1'b0; write_enable = 1'b0;
    tick();

    // ---- reset overrides a concurrent bus write ----
    rst = 1'b1;
    sel_regs = 1'b1; write_enable = 1'b1; reg_addr = 3'd3; data_in = 8'h12;
    tick();
    sel_regs = 1'b0; write_enable = 1'b0; rst = 1'b0;
    bus_read(3'd3, rd); chk("rst_over_write", rd, 8'hFF);
    bus_read(3'd4, rd); chk("rst_frame", rd, 8'h00);
    bus_read(3'd0, rd); chk("rst_status", rd, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
